// File: rtl/divider_pkg.sv
// divider_pkg: shared widths, ALU op codes and FSM states for the shift-subtract divider
package divider_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic ALU_SUB = 1'b1;
    localparam logic ALU_ADD = 1'b0;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_PRESHIFT = 3'd2;
    localparam logic [2:0] ST_SUB      = 3'd3;
    localparam logic [2:0] ST_SHIFT    = 3'd4;
    localparam logic [2:0] ST_ADJUST   = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;
    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        LOAD     = ST_LOAD,
        PRESHIFT = ST_PRESHIFT,
        SUB      = ST_SUB,
        SHIFT    = ST_SHIFT,
        ADJUST   = ST_ADJUST,
        DONE     = ST_DONE
    } div_state_t;
endpackage

// File: rtl/divider_iter_counter.sv
// divider_iter_counter: iteration counter; term flags the increment that reaches WIDTH
module divider_iter_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic inc,
    output logic term
);
    logic [CNT_W-1:0] count;
    assign term = inc && (count == CNT_W'(WIDTH - 1));
    // Count SHIFT cycles, saturating at WIDTH so it can never wrap
    always_ff @(posedge clk)
        if (Reset || clear) count <= '0;
        else if (inc && count != CNT_W'(WIDTH)) count <= count + CNT_W'(1);
    // The counter must never run past WIDTH
    always_ff @(posedge clk)
        if (!Reset) assert (count <= CNT_W'(WIDTH));
endmodule

// File: rtl/divider_controller.sv
// divider_controller: restoring-division sequencer driving the remainder register and ALU
module divider_controller
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic Reset,
    input  logic Run,
    input  logic Divisor_zero,
    input  logic ALU_carry,
    output logic Load_ctrl,
    output logic W_ctrl,
    output logic SLL_ctrl,
    output logic Q_bit,
    output logic SRL_ctrl,
    output logic ALU_op,
    output logic Ready,
    output logic Busy,
    output logic Div_zero
);
    div_state_t state, state_nx;
    logic q_reg, accept, term;
    assign accept = Run && (state == IDLE || state == DONE);
    divider_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .Reset (Reset),
        .clear (accept && !Divisor_zero),
        .inc   (state == SHIFT),
        .term  (term)
    );
    // Next-state: a zero divisor skips straight to DONE without touching the datapath
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (Run) state_nx = Divisor_zero ? DONE : LOAD;
            LOAD:       state_nx = PRESHIFT;
            PRESHIFT:   state_nx = SUB;
            SUB:        state_nx = SHIFT;
            SHIFT:      state_nx = term ? ADJUST : SUB;
            ADJUST:     state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end
    // State, latched quotient bit and divide-by-zero flag
    always_ff @(posedge clk)
        if (Reset) begin
            state    <= IDLE;
            q_reg    <= 1'b0;
            Div_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == SUB) q_reg <= ALU_carry;
            if (accept) Div_zero <= Divisor_zero;
        end
    assign Load_ctrl = state == LOAD;
    assign W_ctrl    = (state == SUB) && ALU_carry;
    assign SLL_ctrl  = state == PRESHIFT || state == SHIFT;
    assign Q_bit     = (state == SHIFT) && q_reg;
    assign SRL_ctrl  = state == ADJUST;
    assign ALU_op    = (state == SUB) ? ALU_SUB : ALU_ADD;
    assign Ready     = state == DONE;
    assign Busy      = state != IDLE && state != DONE;
    // Datapath strobes are mutually exclusive
    always_ff @(posedge clk)
        if (!Reset) assert ($onehot0({Load_ctrl, W_ctrl, SLL_ctrl, SRL_ctrl}));
endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller: controller driving a behavioural remainder register and ALU, checked against a/b and a%b
module tb_divider_controller;
    logic clk = 1'b0, Reset = 1'b1, Run = 1'b0, Divisor_zero = 1'b0, ALU_carry;
    logic Load_ctrl, W_ctrl, SLL_ctrl, Q_bit, SRL_ctrl, ALU_op, Ready, Busy, Div_zero;
    logic [31:0] dividend = '0, divisor = 32'd1;
    logic [63:0] rem = '0;
    int passed = 0, failed = 0, total = 0;
    int n_load = 0, n_w = 0, n_sll = 0, n_srl = 0, n_sub = 0, n_bad = 0;

    always #5 clk = ~clk;

    divider_controller dut (
        .clk(clk), .Reset(Reset), .Run(Run), .Divisor_zero(Divisor_zero), .ALU_carry(ALU_carry),
        .Load_ctrl(Load_ctrl), .W_ctrl(W_ctrl), .SLL_ctrl(SLL_ctrl), .Q_bit(Q_bit),
        .SRL_ctrl(SRL_ctrl), .ALU_op(ALU_op), .Ready(Ready), .Busy(Busy), .Div_zero(Div_zero)
    );

    // ALU subtract: carry means the upper half is at least the divisor
    assign ALU_carry = rem[63:32] >= divisor;

    // Remainder register obeying the controller strobes
    always @(posedge clk)
        if (Load_ctrl) rem <= {32'd0, dividend};
        else if (W_ctrl) rem[63:32] <= rem[63:32] - divisor;
        else if (SLL_ctrl) rem <= {rem[62:0], Q_bit};
        else if (SRL_ctrl) rem[63:32] <= rem[63:32] >> 1;

    // Strobe tallies, sampled mid-cycle
    always @(negedge clk) begin
        n_load += int'(Load_ctrl);
        n_w    += int'(W_ctrl);
        n_sll  += int'(SLL_ctrl);
        n_srl  += int'(SRL_ctrl);
        n_sub  += int'(ALU_op);
        if (int'(Load_ctrl) + int'(W_ctrl) + int'(SLL_ctrl) + int'(SRL_ctrl) > 1) n_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {Load_ctrl, W_ctrl, SLL_ctrl, Q_bit, SRL_ctrl, ALU_op, Ready, Busy, Div_zero};
    endfunction

    task automatic clear_tallies();
        n_load = 0; n_w = 0; n_sll = 0; n_srl = 0; n_sub = 0;
    endtask

    // One full division; stray_at > 0 pulses Run at that cycle while busy
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int stray_at, input string tag);
        int cyc;
        logic [31:0] q, r;
        q = a / b;
        r = a % b;
        @(negedge clk);
        dividend = a; divisor = b; Divisor_zero = 1'b0;
        clear_tallies();
        Run = 1'b1;
        @(negedge clk);
        Run = 1'b0;
        cyc = 1;
        check({tag, "/cycle1"}, {60'd0, Ready, Load_ctrl, Busy, Div_zero}, 64'b0110);
        while (!Ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
            Run = (stray_at > 0 && cyc == stray_at);
        end
        Run = 1'b0;
        check({tag, "/latency"}, 64'(cyc), 64'd68);
        check({tag, "/quot"}, {32'd0, rem[31:0]}, {32'd0, q});
        check({tag, "/rem"}, {32'd0, rem[63:32]}, {32'd0, r});
        check({tag, "/sll"}, 64'(n_sll), 64'd33);
        check({tag, "/srl"}, 64'(n_srl), 64'd1);
        check({tag, "/load"}, 64'(n_load), 64'd1);
        check({tag, "/sub"}, 64'(n_sub), 64'd32);
        check({tag, "/wr"}, 64'(n_w), 64'($countones(q)));
    endtask

    initial begin
        // Reset with Run asserted, then idle
        Run = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_run", {55'd0, outs()}, 64'd0);
        Reset = 1'b0;
        Run = 1'b0;
        repeat (5) @(negedge clk);
        check("idle", {55'd0, outs()}, 64'd0);

        run_div(32'd7, 32'd2, 0, "d7_2");
        run_div(32'hFFFF_FFFF, 32'd1, 0, "dmax_1");
        run_div(32'd0, 32'd5, 0, "d0_5");

        // Divide by zero: immediate DONE with no strobes
        @(negedge clk);
        clear_tallies();
        divisor = '0; Divisor_zero = 1'b1; Run = 1'b1;
        @(negedge clk);
        Run = 1'b0; Divisor_zero = 1'b0;
        check("dz/flags", {61'd0, Ready, Div_zero, Busy}, 64'b110);
        repeat (4) @(negedge clk);
        check("dz/strobes", 64'(n_load + n_w + n_sll + n_srl), 64'd0);
        check("dz/hold", {62'd0, Ready, Div_zero}, 64'b11);
        run_div(32'd100, 32'd7, 0, "after_dz");

        // Abort mid-division with Reset
        @(negedge clk);
        dividend = 32'd1234; divisor = 32'd3; Run = 1'b1;
        @(negedge clk);
        Run = 1'b0;
        repeat (29) @(negedge clk);
        check("abort/busy", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        @(negedge clk);
        check("abort/idle", {55'd0, outs()}, 64'd0);
        Reset = 1'b0;
        run_div(32'd1000, 32'd33, 0, "after_abort");

        // Run while busy is ignored
        run_div(32'd987654321, 32'd12345, 40, "stray_run");

        // Random operands; divisor kept below 2^31 so the 32-bit upper half cannot overflow
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 1) ? 32'($urandom_range(1, 255)) : 32'($urandom_range(1, 32'h7FFF_FFFF));
            run_div(a, b, 0, $sformatf("rand%0d", i));
        end

        check("strobe_excl", 64'(n_bad), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/divider_controller.md
# divider_controller

Sequencing FSM for the 32-bit shift-subtract divider. It drives the remainder register's load, write, shift-left and shift-right strobes, and the ALU operation select, through the restoring-division schedule. It uses the ALU carry to decide each quotient bit and reports completion with `Ready`. It sits beside the remainder register and ALU in the divider top level and is the only source of their control strobes.

## Interface
- `WIDTH`, 32: dividend/divisor width, which is also the iteration count.
- `CNT_W`, `$clog2(WIDTH+1)`: iteration counter width.

- `clk` input 1: single clock; all state changes on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Run` input 1: start request, sampled in IDLE or DONE.
- `Divisor_zero` input 1: divisor == 0, sampled with `Run`.
- `ALU_carry` input 1: ALU carry-out during subtract; 1 = no borrow (difference ≥ 0).
- `Load_ctrl` output 1: load `{0, dividend}` into the remainder register.
- `W_ctrl` output 1: write the ALU result into the remainder upper half.
- `SLL_ctrl` output 1: shift the whole remainder left by 1, inserting `Q_bit` at bit 0.
- `Q_bit` output 1: quotient bit inserted on the shift.
- `SRL_ctrl` output 1: shift the remainder upper half right by 1.
- `ALU_op` output 1: 1 = subtract, 0 = add/idle.
- `Ready` output 1: result valid.
- `Busy` output 1: division in progress.
- `Div_zero` output 1: last accepted request had a zero divisor.

## Operation
- States: IDLE, LOAD, PRESHIFT, SUB, SHIFT, ADJUST, DONE.
- Reset puts the FSM in IDLE and clears the counter and the latched carry. All outputs are 0 after reset, including `Ready` and `Div_zero`.
- IDLE or DONE, with `Run`=1:
  - `Divisor_zero`=1: go to DONE and set `Div_zero`=1. No datapath strobe is issued.
  - Otherwise: go to LOAD, clear `Div_zero` and `Ready`, and clear the counter.
- LOAD: `Load_ctrl`=1, then go to PRESHIFT.
- PRESHIFT: `SLL_ctrl`=1 with `Q_bit`=0, then go to SUB.
- SUB:
  - `ALU_op`=1 and `W_ctrl`=`ALU_carry`, applied combinationally; the register is written only when the difference is non-negative.
  - Latch `ALU_carry` into the quotient-bit register, then go to SHIFT.
- SHIFT:
  - `SLL_ctrl`=1 and `Q_bit`=latched carry; increment the counter.
  - When the counter reaches `WIDTH`, go to ADJUST; otherwise go to SUB.
- ADJUST: `SRL_ctrl`=1, then go to DONE.
- DONE:
  - `Ready`=1 and held until the next accepted `Run`.
  - The quotient is in the remainder lower half; the remainder is in the upper half.
- `Busy`=1 in LOAD through ADJUST inclusive.
- `Run` during `Busy` is ignored, with no queueing.
- At most one of `Load_ctrl`, `W_ctrl`, `SLL_ctrl`, `SRL_ctrl` is high in any cycle.
- `Reset` mid-division aborts the operation. The next cycle is IDLE with all outputs 0, regardless of the counter value.
- `Run` and `Reset` high together: `Reset` wins.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `Run`. Cycle 1 is LOAD, cycle 2 PRESHIFT, cycles 3–66 alternate SUB/SHIFT (32 pairs), cycle 67 ADJUST, cycle 68 DONE.
- Fixed latency: `Ready` rises 68 cycles after `Run` is accepted, independent of the operand values.
- Divide-by-zero: `Ready`=1 and `Div_zero`=1 from cycle 1.
- Back-to-back: `Run` held in DONE restarts immediately. `Ready` drops in the LOAD cycle.
- Outputs are Moore decodes of state, except `W_ctrl`, which is gated by `ALU_carry` in SUB.
- The counter never exceeds `WIDTH`. It must not wrap; checked by assertion.

## Structure
- `divider_pkg`:
  - state enum `div_state_t`
  - `DIV_WIDTH`=32
  - `ALU_SUB`/`ALU_ADD` constants
- Sub-module `divider_iter_counter`: clear, increment, terminal flag at `WIDTH`.
- The FSM and output decode stay in `divider_controller`.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0 and state IDLE. `Run` during `Reset` → still IDLE.
- Dividend 7, divisor 2, with the remainder register and ALU attached → `Ready` at cycle 68; lower half = 3, upper half = 1; exactly 32 `SLL_ctrl` pulses in SHIFT plus 1 in PRESHIFT; 1 `SRL_ctrl` pulse.
- Dividend 0xFFFFFFFF, divisor 1 → every SUB has `ALU_carry`=1 and asserts `W_ctrl`; quotient 0xFFFFFFFF, remainder 0.
- Dividend 0, divisor 5 → every SUB has `ALU_carry`=0 and `W_ctrl` is never asserted; quotient 0, remainder 0; `Ready` still at cycle 68.
- `Run` with `Divisor_zero`=1 → `Ready`=1 and `Div_zero`=1 at cycle 1; zero strobes. Next valid `Run` → `Div_zero` cleared.
- Abort and retrigger:
  - `Reset` pulsed at cycle 30 → IDLE at cycle 31; a new `Run` completes normally in 68 cycles.
  - `Run` pulsed at cycle 40 without `Reset` → ignored.
